// File: rtl/mmio_uart_tx_if.sv
// ============================================================================
// Module  : mmio_uart_tx_if
// Brief   : Processor store/load bus seen by the MMIO UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, output dataadr, output writedata, input readdata);
    modport slave  (input memwrite, input dataadr, input writedata, output readdata);
endinterface

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module  : mmio_uart_tx
// Brief   : MMIO byte FIFO drained by an 8N1 UART transmitter; optional even
//           parity bit when MMIO_UART_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'hFFFF8053,
    parameter logic [31:0] STAT_ADDR    = 32'hFFFF8057,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mmio_uart_tx_if.slave   bus,
    output logic            txd,
    output logic            tx_empty
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_tw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_tw-1:0] c_bit_last = c_tw'(CLKS_PER_BIT - 1);
    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(FIFO_DEPTH);
`ifdef MMIO_UART_PARITY_EN
    localparam logic c_parity_flag = 1'b1;
`else
    localparam logic c_parity_flag = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_tw-1:0]   r_timer;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_txd;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_tick;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_clr;
    logic [7:0]        w_head;
    logic [2:0]        w_next_bit;
    logic [31:0]       w_count_ext;
    logic [3:0]        w_count_sat;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_tick      = (r_timer == c_bit_last);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_next_bit  = r_bit + 3'd1;

    // Pop happens on leaving IDLE or at the very end of a stop bit.
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick));
    assign w_push_req  = bus.memwrite && (bus.dataadr == TX_ADDR);
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_clr       = bus.memwrite && (bus.dataadr == STAT_ADDR);
    assign w_unused    = ^bus.writedata[31:8];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    r_bit   <= '0;
                    r_txd   <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= ST_START;
                        r_txd   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (r_bit == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            r_state <= ST_PARITY;
                            r_txd   <= ^r_shift;
`else
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit <= w_next_bit;
                            r_txd <= r_shift[w_next_bit];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_state <= ST_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= ST_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign w_count_ext = 32'(r_count);
    assign w_count_sat = (w_count_ext > 32'd15) ? 4'd15 : w_count_ext[3:0];
    assign w_status    = {23'd0, c_parity_flag, w_count_sat, r_overflow,
                          (r_state != ST_IDLE), w_empty, w_full};

    assign bus.readdata = (bus.dataadr == STAT_ADDR) ? w_status : 32'd0;
    assign txd          = r_txd;
    assign tx_empty     = w_empty && (r_state == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// Module  : tb_mmio_uart_tx
// Brief   : Directed, table-driven checks of the MMIO UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

    localparam logic [31:0] c_tx   = 32'hFFFF8053;
    localparam logic [31:0] c_stat = 32'hFFFF8057;
    localparam int          c_cpb  = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam logic [31:0] c_par  = 32'h100;
    localparam int          c_nbit = 11;
`else
    localparam logic [31:0] c_par  = 32'h0;
    localparam int          c_nbit = 10;
`endif

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_txd;
        logic        exp_empty;
    } vec_t;

    logic clk;
    logic reset;
    logic txd;
    logic tx_empty;
    int   n_pass;
    int   n_total;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .TX_ADDR      (c_tx),
        .STAT_ADDR    (c_stat),
        .CLKS_PER_BIT (c_cpb),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .txd      (txd),
        .tx_empty (tx_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.dataadr   = a;
        bus.writedata = d;
        cycle();
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'd0;
        bus.writedata = 32'd0;
    endtask

    task automatic read_stat(input string nm, input logic [31:0] exp);
        bus.dataadr = c_stat;
        #1;
        check(nm, bus.readdata, exp | c_par);
        bus.dataadr = 32'd0;
    endtask

    // Checks one whole frame starting at the current cycle, every cycle of every bit.
    task automatic send_bits(input logic [7:0] b, input string nm);
        logic [10:0] f;
        logic        ok;
        logic        bad;
`ifdef MMIO_UART_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {1'b1, 1'b1, b, 1'b0};
`endif
        for (int k = 0; k < c_nbit; k++) begin
            ok  = 1'b1;
            bad = f[k];
            for (int c = 0; c < c_cpb; c++) begin
                if (txd !== f[k]) begin
                    ok  = 1'b0;
                    bad = txd;
                end
                cycle();
            end
            check($sformatf("%s bit%0d", nm, k), {31'd0, bad}, {31'd0, f[k]});
        end
    endtask

    vec_t       vecs [7];
    logic [7:0] bytes6 [6];
    logic       hi_ok;

    initial begin
        n_pass        = 0;
        n_total       = 0;
        reset         = 1'b0;
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'd0;
        bus.writedata = 32'd0;

        vecs[0] = '{1'b0, c_stat,        32'h0,        32'h2 | c_par, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 32'h00000054,  32'hAB,       32'h0,         1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'h00001000,  32'h0,        32'h0,         1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'hFFFF8052,  32'h55,       32'h0,         1'b1, 1'b1};
        vecs[4] = '{1'b0, c_tx,          32'h0,        32'h0,         1'b1, 1'b1};
        vecs[5] = '{1'b1, c_stat,        32'hFFFFFFFF, 32'h2 | c_par, 1'b1, 1'b1};
        vecs[6] = '{1'b0, c_stat,        32'h0,        32'h2 | c_par, 1'b1, 1'b1};

        repeat (3) cycle();
        check("reset txd", {31'd0, txd}, 32'd1);
        check("reset tx_empty", {31'd0, tx_empty}, 32'd1);
        read_stat("reset status", 32'h2);
        reset = 1'b1;
        cycle();

        for (int i = 0; i < 7; i++) begin
            bus.memwrite  = vecs[i].we;
            bus.dataadr   = vecs[i].adr;
            bus.writedata = vecs[i].wd;
            #1;
            check($sformatf("vec%0d readdata", i), bus.readdata, vecs[i].exp_rd);
            cycle();
            bus.memwrite  = 1'b0;
            bus.dataadr   = 32'd0;
            bus.writedata = 32'd0;
            check($sformatf("vec%0d txd", i), {31'd0, txd}, {31'd0, vecs[i].exp_txd});
            check($sformatf("vec%0d tx_empty", i), {31'd0, tx_empty}, {31'd0, vecs[i].exp_empty});
        end

        // Single frame of 0x01, including first-edge latency.
        store(c_tx, 32'h1);
        read_stat("queued status", 32'h10);
        check("queued tx_empty", {31'd0, tx_empty}, 32'd0);
        check("queued txd", {31'd0, txd}, 32'd1);
        cycle();
        read_stat("start status", 32'h6);
        send_bits(8'h01, "f01");
        check("f01 tx_empty", {31'd0, tx_empty}, 32'd1);
        read_stat("f01 idle status", 32'h2);

        // Back-to-back frames without idle gap.
        store(c_tx, 32'hA5);
        store(c_tx, 32'h3C);
        send_bits(8'hA5, "fA5");
        send_bits(8'h3C, "f3C");
        check("b2b tx_empty", {31'd0, tx_empty}, 32'd1);

        // Overflow, clear, and same-edge push/pop on a full FIFO.
        bytes6[0] = 8'h81; bytes6[1] = 8'h42; bytes6[2] = 8'hC3;
        bytes6[3] = 8'h24; bytes6[4] = 8'hE5; bytes6[5] = 8'h66;
        for (int i = 0; i < 6; i++) begin
            store(c_tx, {24'hDEAD00, bytes6[i]});
        end
        read_stat("overflow status", 32'h4D);
        store(c_stat, 32'h12345678);
        read_stat("cleared status", 32'h45);
        repeat (34) cycle();
        store(c_tx, 32'h99);
        read_stat("full push+pop status", 32'h45);
        send_bits(8'h42, "q42");
        send_bits(8'hC3, "qC3");
        send_bits(8'h24, "q24");
        send_bits(8'hE5, "qE5");
        send_bits(8'h99, "q99");
        check("drain tx_empty", {31'd0, tx_empty}, 32'd1);

        // Asynchronous reset during the data phase.
        store(c_tx, 32'h0);
        store(c_tx, 32'h0);
        repeat (6) cycle();
        check("pre-reset txd", {31'd0, txd}, 32'd0);
        reset = 1'b0;
        #1;
        check("async reset txd", {31'd0, txd}, 32'd1);
        check("async reset tx_empty", {31'd0, tx_empty}, 32'd1);
        cycle();
        reset = 1'b1;
        read_stat("post-reset status", 32'h2);
        hi_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (txd !== 1'b1 || tx_empty !== 1'b1) hi_ok = 1'b0;
            cycle();
        end
        check("post-reset line quiet", {31'd0, hi_ok}, 32'd1);

        // Odd-weight byte (parity bit 1 when parity is enabled).
        store(c_tx, 32'h07);
        cycle();
        send_bits(8'h07, "f07");
        check("f07 tx_empty", {31'd0, tx_empty}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
